// File: rtl/z80_spi_bus_sync_pkg.sv
// Shared DivMMC definitions: port numbers, FSM encoding, counter width.
// Z80_WAIT_EN adds the WAIT_BUSY state used by the wait-state build.
package divmmc_pkg;

  localparam logic [7:0] PORT_E3 = 8'hE3;
  localparam logic [7:0] PORT_E7 = 8'hE7;
  localparam logic [7:0] PORT_EB = 8'hEB;

  localparam int COLL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
`ifdef Z80_WAIT_EN
    ST_WAIT_BUSY = 2'd1,
`endif
    ST_HOLD      = 2'd2
  } state_t;

  function automatic logic [COLL_W-1:0] sat_inc(
    input logic [COLL_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/z80_spi_bus_sync_sync_ff.sv
// Multi-flop synchroniser for an active-low asynchronous strobe.
// All stages reset to 1 (strobe inactive).
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '1;
    else     sr <= {sr[DEPTH-2:0], d};
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/z80_spi_bus_sync.sv
// Z80 I/O front end for the DivMMC SPI master: one start pulse per I/O cycle.
// Optional Z80_WAIT_EN stretches colliding accesses with WAIT instead of dropping.
module z80_spi_bus_sync
  import divmmc_pkg::*;
#(
  parameter logic [7:0] PORT_SPI    = PORT_EB,
  parameter int         SYNC_STAGES = 2,
  parameter int         WAIT_MAX    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        a,
  input  logic [7:0]        d_in,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  input  logic              spi_busy,
  input  logic [7:0]        spi_rx_data,
  output logic              start_wr,
  output logic              start_rd,
  output logic [7:0]        tx_data,
  output logic [7:0]        cpu_dout,
  output logic              cpu_oe,
  output logic              wait_n,
  output logic [COLL_W-1:0] collisions
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (WAIT_MAX < 1) begin : g_bad_wait
    $error("WAIT_MAX must be at least 1");
  end

  localparam int FCW = $clog2(SYNC_STAGES + 1);

  logic       iorq_s, rd_s, wr_s;
  logic [7:0] a_q, d_q;
  logic       m1_q;
  logic       sel, acc_wr, acc_rd, go;
  logic       armed;
  logic [FCW-1:0] flush_cnt;

  state_t state, state_nx;
  logic   start_wr_nx, start_rd_nx;
  logic   tx_ld, coll_inc;

  logic       busy_q, rx_pend;
  logic [7:0] rx_buf;
  logic       rx_fall;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_iorq (
    .clk (clk), .rst (rst), .d (iorq_n), .q (iorq_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_rd (
    .clk (clk), .rst (rst), .d (rd_n), .q (rd_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_wr (
    .clk (clk), .rst (rst), .d (wr_n), .q (wr_s)
  );

  // Address, data and M1 are stable through the I/O cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '1;
      d_q  <= '1;
      m1_q <= 1'b1;
    end else begin
      a_q  <= a;
      d_q  <= d_in;
      m1_q <= m1_n;
    end
  end

  assign sel    = (a_q == PORT_SPI) & m1_q;
  assign acc_wr = sel & ~iorq_s & ~wr_s;
  assign acc_rd = sel & ~iorq_s & ~rd_s;
  assign go     = armed & (acc_wr | acc_rd);

  assign cpu_oe = (a == PORT_SPI) & m1_n & ~iorq_n & ~rd_n;

  // After reset, accept nothing until a flushed pipe shows the bus idle,
  // so a cycle cut by reset never produces a late pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (flush_cnt != FCW'(SYNC_STAGES))
        flush_cnt <= flush_cnt + 1'b1;
      if (flush_cnt == FCW'(SYNC_STAGES) && iorq_s)
        armed <= 1'b1;
    end
  end

`ifdef Z80_WAIT_EN
  localparam int WCW = $clog2(WAIT_MAX + 1);

  logic [WCW-1:0] wait_cnt;
  logic           wait_to;
  logic           pend_wr;
  logic           wait_rel;

  assign wait_to = (wait_cnt == WCW'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      pend_wr  <= 1'b0;
      wait_rel <= 1'b0;
    end else begin
      if (state == ST_WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;
      if (state == ST_IDLE && go) pend_wr <= acc_wr;
      if (state == ST_WAIT_BUSY && spi_busy && wait_to)
        wait_rel <= 1'b1;
      else if (state == ST_IDLE)
        wait_rel <= 1'b0;
    end
  end

  assign wait_n = rst | ~((a == PORT_SPI) & m1_n & ~iorq_n
                  & (spi_busy | state == ST_WAIT_BUSY) & ~wait_rel);
`else
  assign wait_n = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (go) begin
`ifdef Z80_WAIT_EN
          state_nx = spi_busy ? ST_WAIT_BUSY : ST_HOLD;
`else
          state_nx = ST_HOLD;
`endif
        end
      end
`ifdef Z80_WAIT_EN
      ST_WAIT_BUSY: begin
        if (!spi_busy || wait_to) state_nx = ST_HOLD;
      end
`endif
      ST_HOLD: begin
        if (iorq_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Write wins if both strobes appear together.
  always_comb begin
    start_wr_nx = 1'b0;
    start_rd_nx = 1'b0;
    tx_ld       = 1'b0;
    coll_inc    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (go) begin
          tx_ld = acc_wr;
          if (!spi_busy) begin
            start_wr_nx = acc_wr;
            start_rd_nx = ~acc_wr;
          end
`ifndef Z80_WAIT_EN
          else begin
            coll_inc = 1'b1;
          end
`endif
        end
      end
`ifdef Z80_WAIT_EN
      ST_WAIT_BUSY: begin
        if (!spi_busy) begin
          start_wr_nx = pend_wr;
          start_rd_nx = ~pend_wr;
        end else if (wait_to) begin
          coll_inc = 1'b1;
        end
      end
`endif
      ST_HOLD: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_wr   <= 1'b0;
      start_rd   <= 1'b0;
      tx_data    <= 8'hFF;
      collisions <= '0;
    end else begin
      start_wr <= start_wr_nx;
      start_rd <= start_rd_nx;
      if (tx_ld)    tx_data    <= d_q;
      if (coll_inc) collisions <= sat_inc(collisions);
    end
  end

  assign rx_fall = busy_q & ~spi_busy;

  // Never change the byte under an active CPU read.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      rx_pend  <= 1'b0;
      rx_buf   <= 8'hFF;
      cpu_dout <= 8'hFF;
    end else begin
      busy_q <= spi_busy;
      if (rx_fall) begin
        if (cpu_oe) begin
          rx_buf  <= spi_rx_data;
          rx_pend <= 1'b1;
        end else begin
          cpu_dout <= spi_rx_data;
          rx_pend  <= 1'b0;
        end
      end else if (rx_pend && !cpu_oe) begin
        cpu_dout <= rx_buf;
        rx_pend  <= 1'b0;
      end
    end
  end

endmodule
